// File: rtl/uart_pkg.sv
// Shared types and default frame constants for the UART command link.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   localparam logic [7:0] DEF_CMD_A    = 8'h01;
   localparam logic [7:0] DEF_CMD_B    = 8'h02;
   localparam logic [7:0] DEF_END_BYTE = 8'h0F;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampled UART receiver: 2-flop synchroniser, mid-bit sampling,
// one-cycle byte strobe and framing-error strobe.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_strobe,
   output logic                 o_ferr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

   logic [1:0]           r_sync;
   logic                 w_rx;
   rx_state_t            r_state, w_state_n;
   logic [CW-1:0]        r_cnt, w_cnt_n;
   logic [BW-1:0]        r_bit, w_bit_n;
   logic [DATA_BITS-1:0] r_shift, w_shift_n;

   assign w_rx   = r_sync[1];
   assign o_data = r_shift;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync  <= 2'b11;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_rx};
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + CW'(1);
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      o_strobe  = 1'b0;
      o_ferr    = 1'b0;
      unique case (r_state)
         RX_IDLE: begin
            w_cnt_n = '0;
            if (!w_rx) w_state_n = RX_START;
         end
         RX_START: begin
            if (r_cnt == HALF) begin
               w_cnt_n   = '0;
               w_bit_n   = '0;
               w_state_n = w_rx ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt == FULL) begin
               w_cnt_n   = '0;
               w_shift_n = {w_rx, r_shift[DATA_BITS-1:1]};
               if (r_bit == LAST) w_state_n = RX_STOP;
               else w_bit_n = r_bit + BW'(1);
            end
         end
         RX_STOP: begin
            if (r_cnt == FULL) begin
               w_cnt_n = '0;
               if (w_rx) begin
                  o_strobe  = 1'b1;
                  w_state_n = RX_IDLE;
               end else begin
                  o_ferr    = 1'b1;
                  w_state_n = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            w_cnt_n = '0;
            if (w_rx) w_state_n = RX_IDLE;
         end
         default: begin
            w_cnt_n   = '0;
            w_state_n = RX_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/uart_cmd_link.sv
// UART command link: frame assembler with abort checks on the RX side,
// valid/ready serialiser on the TX side.
module uart_cmd_link
   import uart_pkg::*;
#(
   parameter int                   CLKS_PER_BIT = 868,
   parameter int                   DATA_BITS    = 8,
   parameter int                   FRAME_BYTES  = 6,
   parameter logic [DATA_BITS-1:0] CMD_A        = DATA_BITS'(DEF_CMD_A),
   parameter logic [DATA_BITS-1:0] CMD_B        = DATA_BITS'(DEF_CMD_B),
   parameter logic [DATA_BITS-1:0] END_BYTE     = DATA_BITS'(DEF_END_BYTE),
   parameter int                   TIMEOUT_BITS = 20
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             UART_RX,
   output logic                             UART_TX,
   input  logic [DATA_BITS-1:0]             tx_data_i,
   input  logic                             tx_valid_i,
   output logic                             tx_ready_o,
   output logic [DATA_BITS*FRAME_BYTES-1:0] RX_buff,
   output logic                             Data_Ready,
   output logic                             frame_valid_o,
   output logic                             frame_error_o
);

   localparam int IW   = $clog2(FRAME_BYTES);
   localparam int TOUT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW   = $clog2(TOUT + 1);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES - 1);
   localparam logic [TW-1:0] TO_END   = TW'(TOUT - 1);
   localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST     = BW'(DATA_BITS - 1);

   logic [DATA_BITS-1:0] w_byte;
   logic                 w_strobe;
   logic                 w_ferr;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .DATA_BITS   (DATA_BITS)
   ) u_rx (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_rx    (UART_RX),
      .o_data  (w_byte),
      .o_strobe(w_strobe),
      .o_ferr  (w_ferr)
   );

   // Working slots FRAME_BYTES-1..1; the terminator never needs storing.
   logic [FRAME_BYTES-1:1][DATA_BITS-1:0] r_work;
   logic [DATA_BITS*FRAME_BYTES-1:0]      r_buff;
   logic [IW-1:0]                         r_idx;
   logic [IW-1:0]                         w_slot;
   logic [TW-1:0]                         r_to;
   logic                                  w_timeout;
   logic                                  r_dr, r_fv, r_fe;

   assign w_slot        = IDX_LAST - r_idx;
   assign w_timeout     = (r_idx != '0) && (r_to == TO_END);
   assign RX_buff       = r_buff;
   assign Data_Ready    = r_dr;
   assign frame_valid_o = r_fv;
   assign frame_error_o = r_fe;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_work <= '0;
         r_buff <= '0;
         r_idx  <= '0;
         r_to   <= '0;
         r_dr   <= 1'b0;
         r_fv   <= 1'b0;
         r_fe   <= 1'b0;
      end else begin
         r_fv <= 1'b0;
         r_fe <= 1'b0;
         if (w_strobe || r_idx == '0) r_to <= '0;
         else r_to <= r_to + TW'(1);
         if (w_strobe) begin
            if (r_idx == '0) begin
               if (w_byte == CMD_A || w_byte == CMD_B) begin
                  r_work[FRAME_BYTES-1] <= w_byte;
                  r_idx <= IW'(1);
                  r_dr  <= 1'b0;
               end
            end else if (r_idx == IDX_LAST) begin
               r_idx <= '0;
               if (w_byte == END_BYTE) begin
                  r_buff <= {r_work, w_byte};
                  r_fv   <= 1'b1;
                  r_dr   <= 1'b1;
               end else begin
                  r_fe <= 1'b1;
               end
            end else begin
               r_work[w_slot] <= w_byte;
               r_idx <= r_idx + IW'(1);
            end
         end else if (r_idx != '0 && (w_ferr || w_timeout)) begin
            r_idx <= '0;
            r_fe  <= 1'b1;
         end
      end
   end

   tx_state_t            r_ts, w_ts_n;
   logic [CW-1:0]        r_tc, w_tc_n;
   logic [BW-1:0]        r_tb, w_tb_n;
   logic [DATA_BITS-1:0] r_tsh, w_tsh_n;
   logic                 r_txd, w_txd_n;

   assign tx_ready_o = (r_ts == TX_IDLE);
   assign UART_TX    = r_txd;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ts  <= TX_IDLE;
         r_tc  <= '0;
         r_tb  <= '0;
         r_tsh <= '0;
         r_txd <= 1'b1;
      end else begin
         r_ts  <= w_ts_n;
         r_tc  <= w_tc_n;
         r_tb  <= w_tb_n;
         r_tsh <= w_tsh_n;
         r_txd <= w_txd_n;
      end
   end

   always_comb begin
      w_ts_n  = r_ts;
      w_tc_n  = r_tc + CW'(1);
      w_tb_n  = r_tb;
      w_tsh_n = r_tsh;
      unique case (r_ts)
         TX_IDLE: begin
            w_tc_n = '0;
            if (tx_valid_i) begin
               w_tsh_n = tx_data_i;
               w_ts_n  = TX_START;
            end
         end
         TX_START: begin
            if (r_tc == FULL) begin
               w_tc_n = '0;
               w_tb_n = '0;
               w_ts_n = TX_DATA;
            end
         end
         TX_DATA: begin
            if (r_tc == FULL) begin
               w_tc_n  = '0;
               w_tsh_n = {1'b0, r_tsh[DATA_BITS-1:1]};
               if (r_tb == LAST) w_ts_n = TX_STOP;
               else w_tb_n = r_tb + BW'(1);
            end
         end
         TX_STOP: begin
            if (r_tc == FULL) begin
               w_tc_n = '0;
               w_ts_n = TX_IDLE;
            end
         end
         default: begin
            w_tc_n = '0;
            w_ts_n = TX_IDLE;
         end
      endcase
      // Line level follows the state being entered so the pin is a flop.
      w_txd_n = (w_ts_n == TX_START) ? 1'b0 :
                (w_ts_n == TX_DATA)  ? w_tsh_n[0] : 1'b1;
   end

endmodule
